// File: rtl/usr_nbit_shift_if.sv
// Bus bundle for usr_nbit_shift: control, serial/parallel data in, stage outputs.
interface usr_nbit_shift_if #(
    parameter int unsigned W = 1,
    parameter int unsigned N = 4
);
    logic           clr_in;
    logic [1:0]     mode_in;
    logic [W-1:0]   d_in;
    logic           rot_in;
    logic [W*N-1:0] par_in;
    logic [W*N-1:0] par_out;
    logic [W-1:0]   q_fwd_out;
    logic [W-1:0]   q_rev_out;
    logic           valid_out;

    modport master (
        output clr_in, mode_in, d_in, rot_in, par_in,
        input  par_out, q_fwd_out, q_rev_out, valid_out
    );

    modport slave (
        input  clr_in, mode_in, d_in, rot_in, par_in,
        output par_out, q_fwd_out, q_rev_out, valid_out
    );
endinterface

// File: rtl/usr_nbit_shift.sv
// Universal N-stage, W-bit shift register with hold/forward/reverse/load and a saturating fill count.
// Optional recirculation (rot_in) is built only when USR_ROTATE_EN is defined.
module usr_nbit_shift #(
    parameter int unsigned W = 1,
    parameter int unsigned N = 4
) (
    input logic              clk,
    input logic              reset_ah_in,
    usr_nbit_shift_if.slave  bus
);
    localparam int unsigned FW = $clog2(N + 1);
    localparam logic [FW-1:0] FULL = FW'(N);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_FWD  = 2'b01,
        MODE_REV  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [N-1:0][W-1:0] stage_q, stage_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [FW-1:0]       fill_inc;
    logic [W-1:0]        fwd_in, rev_in;
    mode_e               mode;

    assign mode     = mode_e'(bus.mode_in);
    assign fill_inc = (fill_q == FULL) ? fill_q : fill_q + 1'b1;

`ifdef USR_ROTATE_EN
    assign fwd_in = bus.rot_in ? stage_q[N-1] : bus.d_in;
    assign rev_in = bus.rot_in ? stage_q[0]   : bus.d_in;
`else
    logic unused_rot;
    assign unused_rot = bus.rot_in;
    assign fwd_in     = bus.d_in;
    assign rev_in     = bus.d_in;
`endif

    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        if (bus.clr_in) begin
            stage_d = '0;
            fill_d  = '0;
        end else begin
            case (mode)
                MODE_HOLD: ;
                MODE_FWD: begin
                    for (int unsigned k = 1; k < N; k++) stage_d[k] = stage_q[k-1];
                    stage_d[0] = fwd_in;
                    fill_d     = fill_inc;
                end
                MODE_REV: begin
                    for (int unsigned k = 0; k < N - 1; k++) stage_d[k] = stage_q[k+1];
                    stage_d[N-1] = rev_in;
                    fill_d       = fill_inc;
                end
                MODE_LOAD: begin
                    stage_d = bus.par_in;
                    fill_d  = FULL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            stage_q <= '0;
            fill_q  <= '0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
        end
    end

    // Packed stage array already matches the par_in/par_out lane layout.
    assign bus.par_out   = stage_q;
    assign bus.q_fwd_out = stage_q[N-1];
    assign bus.q_rev_out = stage_q[0];
    assign bus.valid_out = (fill_q == FULL);
endmodule

// File: tb/tb_usr_nbit_shift.sv
// Directed self-checking bench for usr_nbit_shift at W=4, N=4; rotate expectations follow USR_ROTATE_EN.
module tb_usr_nbit_shift;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    usr_nbit_shift_if #(.W(4), .N(4)) bus ();

    usr_nbit_shift #(.W(4), .N(4)) dut (
        .clk         (clk),
        .reset_ah_in (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.clr_in     = 1'b0;
        bus.mode_in    = 2'b00;
        bus.d_in       = 4'h0;
        bus.rot_in     = 1'b0;
        bus.par_in     = 16'h0000;
        step();
        step();
        check("reset_par", bus.par_out, 16'h0000);
        check("reset_qf", {12'h0, bus.q_fwd_out}, 16'h0000);
        check("reset_qr", {12'h0, bus.q_rev_out}, 16'h0000);
        check("reset_valid", {15'h0, bus.valid_out}, 16'h0000);
        rst = 1'b0;

        // Forward latency
        bus.mode_in = 2'b01;
        bus.d_in = 4'h1; step();
        bus.d_in = 4'h2; step();
        bus.d_in = 4'h3; step();
        check("fwd3_qf", {12'h0, bus.q_fwd_out}, 16'h0000);
        check("fwd3_valid", {15'h0, bus.valid_out}, 16'h0000);
        check("fwd3_par", bus.par_out, 16'h0123);
        bus.d_in = 4'h4; step();
        check("fwd4_qf", {12'h0, bus.q_fwd_out}, 16'h0001);
        check("fwd4_par", bus.par_out, 16'h1234);
        check("fwd4_valid", {15'h0, bus.valid_out}, 16'h0001);
        bus.d_in = 4'h5; step();
        check("fwd5_qf", {12'h0, bus.q_fwd_out}, 16'h0002);
        check("fwd5_par", bus.par_out, 16'h2345);

        // Load then reverse
        bus.mode_in = 2'b11; bus.par_in = 16'h4321; step();
        check("load_qr", {12'h0, bus.q_rev_out}, 16'h0001);
        check("load_qf", {12'h0, bus.q_fwd_out}, 16'h0004);
        check("load_valid", {15'h0, bus.valid_out}, 16'h0001);
        bus.mode_in = 2'b10; bus.d_in = 4'h9; step();
        check("rev_par", bus.par_out, 16'h9432);
        check("rev_qr", {12'h0, bus.q_rev_out}, 16'h0002);
        check("rev_valid", {15'h0, bus.valid_out}, 16'h0001);

        // Clear wins over load
        bus.clr_in = 1'b1; bus.mode_in = 2'b11; bus.par_in = 16'hFFFF; step();
        check("clr_par", bus.par_out, 16'h0000);
        check("clr_valid", {15'h0, bus.valid_out}, 16'h0000);
        bus.clr_in = 1'b0; bus.mode_in = 2'b01; bus.d_in = 4'h7;
        for (int i = 0; i < 3; i++) begin
            step();
            check("clr_refill_valid", {15'h0, bus.valid_out}, 16'h0000);
        end
        step();
        check("clr_refill4_valid", {15'h0, bus.valid_out}, 16'h0001);
        check("clr_refill4_par", bus.par_out, 16'h7777);

        // Async reset mid-shift
        bus.clr_in = 1'b1; step();
        bus.clr_in = 1'b0; bus.mode_in = 2'b01;
        bus.d_in = 4'hA; step();
        bus.d_in = 4'hB; step();
        check("pre_rst_par", bus.par_out, 16'h00AB);
        rst = 1'b1;
        #1;
        check("async_rst_par", bus.par_out, 16'h0000);
        check("async_rst_qf", {12'h0, bus.q_fwd_out}, 16'h0000);
        check("async_rst_qr", {12'h0, bus.q_rev_out}, 16'h0000);
        check("async_rst_valid", {15'h0, bus.valid_out}, 16'h0000);
        bus.d_in = 4'hC; step();
        check("rst_held_par", bus.par_out, 16'h0000);
        rst = 1'b0;
        step();
        check("post_rst_par", bus.par_out, 16'h000C);
        check("post_rst_valid", {15'h0, bus.valid_out}, 16'h0000);
        bus.d_in = 4'hD; step();
        bus.d_in = 4'hE; step();
        check("post_rst3_valid", {15'h0, bus.valid_out}, 16'h0000);
        bus.d_in = 4'hF; step();
        check("post_rst4_valid", {15'h0, bus.valid_out}, 16'h0001);
        check("post_rst4_par", bus.par_out, 16'hCDEF);

        // Hold
        bus.mode_in = 2'b11; bus.par_in = 16'hBEEF; step();
        bus.mode_in = 2'b00;
        for (int i = 0; i < 10; i++) begin
            bus.d_in = (i % 2 == 0) ? 4'h5 : 4'hA;
            step();
            check("hold_par", bus.par_out, 16'hBEEF);
            check("hold_valid", {15'h0, bus.valid_out}, 16'h0001);
        end

        // Rotate select
        bus.mode_in = 2'b11; bus.par_in = 16'h4321; step();
        bus.mode_in = 2'b01; bus.rot_in = 1'b1; bus.d_in = 4'h0; step();
`ifdef USR_ROTATE_EN
        check("rot_fwd1_par", bus.par_out, 16'h3214);
`else
        check("rot_fwd1_par", bus.par_out, 16'h3210);
`endif
        step(); step(); step();
`ifdef USR_ROTATE_EN
        check("rot_fwd4_par", bus.par_out, 16'h4321);
`else
        check("rot_fwd4_par", bus.par_out, 16'h0000);
`endif
        check("rot_fwd4_valid", {15'h0, bus.valid_out}, 16'h0001);
        bus.mode_in = 2'b11; bus.par_in = 16'h4321; step();
        bus.mode_in = 2'b10; step();
`ifdef USR_ROTATE_EN
        check("rot_rev1_par", bus.par_out, 16'h1432);
`else
        check("rot_rev1_par", bus.par_out, 16'h0432);
`endif
        bus.rot_in = 1'b0; bus.mode_in = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
